wb_grf: RTL and testbench

Write-back stage and general register file of the five-stage MIPS pipeline. Consumes the W-stage outputs of the M/W pipeline register, selects and sub-word-extends the write-back value, commits it to the 32×32 register file, and serves the two combinational D-stage read ports. Also exports the W-stage write (enable, register, data) to the hazard/forwarding unit and counts retired instructions.

---
 rtl/wb_grf_pkg.sv | 30 +++
 rtl/wb_grf_if.sv | 48 ++++
 rtl/wb_grf_load_ext.sv | 51 +++++
 rtl/wb_grf.sv | 105 ++++++++++
 tb/tb_wb_grf.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_grf_pkg.sv
// ============================================================================
//  Module   : wb_grf_pkg
//  Purpose  : Shared constants for the MIPS write-back stage and register
//             file: load opcodes, write-back source encoding, register count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_grf_pkg;

  // Load opcodes (instruction bits [31:26])
  localparam logic [5:0] c_OP_LW  = 6'b100011;
  localparam logic [5:0] c_OP_LB  = 6'b100000;
  localparam logic [5:0] c_OP_LBU = 6'b100100;
  localparam logic [5:0] c_OP_LH  = 6'b100001;
  localparam logic [5:0] c_OP_LHU = 6'b100101;

  // Write-back source select, encoded as {W_con2, W_con1}
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC8  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam int c_REG_COUNT = 32;

endpackage : wb_grf_pkg

`default_nettype wire

// File: rtl/wb_grf_if.sv
// ============================================================================
//  Module   : wb_grf_if
//  Purpose  : W-stage bundle between the M/W pipeline register, the
//             write-back/register-file block, the D-stage readers and the
//             hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_grf_if;

  // W-stage pipeline register outputs
  logic [31:0] W_ReadData;
  logic [31:0] W_ALUData;
  logic [4:0]  W_TargetReg;
  logic [2:0]  W_T_new;
  logic [31:0] W_Ins;
  logic [31:0] W_PCAddr;
  logic        W_con1;
  logic        W_con2;

  // D-stage read ports
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  // Write-back export and retirement counter
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  modport master (
    output W_ReadData, W_ALUData, W_TargetReg, W_T_new, W_Ins, W_PCAddr,
           W_con1, W_con2, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_we, wb_reg, wb_data, retire_cnt
  );

  modport slave (
    input  W_ReadData, W_ALUData, W_TargetReg, W_T_new, W_Ins, W_PCAddr,
           W_con1, W_con2, rs_addr, rt_addr,
    output rs_data, rt_data, wb_we, wb_reg, wb_data, retire_cnt
  );

endinterface : wb_grf_if

`default_nettype wire

// File: rtl/wb_grf_load_ext.sv
// ============================================================================
//  Module   : wb_load_ext
//  Purpose  : Sub-word load extraction. Picks the byte/halfword lane named
//             by the low address bits and sign- or zero-extends it; word
//             loads and unknown opcodes pass the raw word through.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane selection; lane 0 is the least-significant byte of the word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Halfword lane selection; address bit 0 is deliberately ignored
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  // Extension according to the load opcode
  always_comb begin
    o_data = i_word;
    case (i_opcode)
      c_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: o_data = {24'd0, w_byte};
      c_OP_LH:  o_data = {{16{w_half[15]}}, w_half};
      c_OP_LHU: o_data = {16'd0, w_half};
      default:  o_data = i_word;
    endcase
  end

endmodule : wb_load_ext

`default_nettype wire

// File: rtl/wb_grf.sv
// ============================================================================
//  Module   : wb_grf
//  Purpose  : MIPS W stage: selects and extends the write-back value,
//             commits it to the 32x32 register file, serves two
//             combinational D-stage read ports, exports the W write to the
//             hazard unit and counts retired (non-bubble) instructions.
//  Options  : GRF_BYPASS_EN - when defined, a read of the register being
//             written this cycle returns the incoming write-back value.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_grf
  import wb_grf_pkg::*;
(
  input  logic     clk,
  input  logic     reset,   // asynchronous, active-low
  wb_grf_if.slave  bus
);

  wb_sel_e     w_sel;
  logic [31:0] w_load_data;
  logic [31:0] w_pc8;
  logic [31:0] w_wb_data;
  logic        w_we;
  logic [31:0] w_rs_stored;
  logic [31:0] w_rt_stored;

  logic [31:0] r_regs [1:c_REG_COUNT-1];  // $0 is hard-wired, not stored
  logic [31:0] r_retire_cnt;

  assign w_sel = wb_sel_e'({bus.W_con2, bus.W_con1});
  assign w_pc8 = bus.W_PCAddr + 32'd8;
  assign w_we  = (bus.W_TargetReg != 5'd0);

  wb_load_ext u_load_ext (
    .i_word   (bus.W_ReadData),
    .i_addr   (bus.W_ALUData[1:0]),
    .i_opcode (bus.W_Ins[31:26]),
    .o_data   (w_load_data)
  );

  // Write-back source mux; the reserved encoding falls back to the ALU result
  always_comb begin
    w_wb_data = bus.W_ALUData;
    case (w_sel)
      WB_SEL_ALU:  w_wb_data = bus.W_ALUData;
      WB_SEL_LOAD: w_wb_data = w_load_data;
      WB_SEL_PC8:  w_wb_data = w_pc8;
      WB_SEL_RSVD: w_wb_data = bus.W_ALUData;
      default:     w_wb_data = bus.W_ALUData;
    endcase
  end

  // Register file: asynchronous clear, commit on the rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < c_REG_COUNT; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_we) begin
      r_regs[bus.W_TargetReg] <= w_wb_data;
    end
  end

  // Retired-instruction counter; bubbles (all-zero instruction) do not count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= 32'd0;
    end else if (bus.W_Ins != 32'd0) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  // Stored read values with $0 forced to zero
  always_comb begin
    w_rs_stored = (bus.rs_addr == 5'd0) ? 32'd0 : r_regs[bus.rs_addr];
    w_rt_stored = (bus.rt_addr == 5'd0) ? 32'd0 : r_regs[bus.rt_addr];
  end

`ifdef GRF_BYPASS_EN
  logic w_rs_hit;
  logic w_rt_hit;

  // Same-cycle bypass; suppressed while reset holds the file at zero
  always_comb begin
    w_rs_hit = reset && w_we && (bus.rs_addr == bus.W_TargetReg);
    w_rt_hit = reset && w_we && (bus.rt_addr == bus.W_TargetReg);
  end

  assign bus.rs_data = w_rs_hit ? w_wb_data : w_rs_stored;
  assign bus.rt_data = w_rt_hit ? w_wb_data : w_rt_stored;
`else
  assign bus.rs_data = w_rs_stored;
  assign bus.rt_data = w_rt_stored;
`endif

  assign bus.wb_we      = w_we;
  assign bus.wb_reg     = bus.W_TargetReg;
  assign bus.wb_data    = w_wb_data;
  assign bus.retire_cnt = r_retire_cnt;

endmodule : wb_grf

`default_nettype wire

// File: tb/tb_wb_grf.sv
// ============================================================================
//  Module   : tb_wb_grf
//  Purpose  : Self-checking bench for wb_grf with a behavioural register-file
//             model. Honours GRF_BYPASS_EN for same-cycle read expectations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_grf;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;

  logic clk = 1'b0;
  logic reset;

  wb_grf_if bus ();

  wb_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;

  // Reference write-back value computed from the ISA rules
  function automatic logic [31:0] ref_wb(input logic [1:0] sel,
                                         input logic [31:0] ins, alu, rd, pc);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * alu[1:0]));
    h = 16'(rd >> (16 * alu[1]));
    if (sel == 2'd2) return pc + 32'd8;
    if (sel != 2'd1) return alu;
    case (ins[31:26])
      OP_LB:   return 32'($signed(b));
      OP_LBU:  return {24'd0, b};
      OP_LH:   return 32'($signed(h));
      OP_LHU:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb_now();
    return ref_wb({bus.W_con2, bus.W_con1}, bus.W_Ins, bus.W_ALUData,
                  bus.W_ReadData, bus.W_PCAddr);
  endfunction

  // Expected read-port value for the current (pre-edge) state
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
    if (reset && bus.W_TargetReg != 5'd0 && a == bus.W_TargetReg) return ref_wb_now();
`endif
    return m_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] ins,
                       input logic [4:0] tgt, input logic [31:0] alu, rd, pc);
    {bus.W_con2, bus.W_con1} = sel;
    bus.W_Ins       = ins;
    bus.W_TargetReg = tgt;
    bus.W_ALUData   = alu;
    bus.W_ReadData  = rd;
    bus.W_PCAddr    = pc;
    bus.W_T_new     = 3'd0;
  endtask

  task automatic bubble();
    drive(2'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One clock edge; the model commits what the spec says the edge commits
  task automatic tick();
    logic [31:0] exp_wb;
    exp_wb = ref_wb_now();
    @(posedge clk);
    if (reset) begin
      if (bus.W_TargetReg != 5'd0) m_rf[bus.W_TargetReg] = exp_wb;
      if (bus.W_Ins != 32'd0) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bubble();
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = 5'(a);
      bus.rt_addr = 5'(31 - a);
      #1;
      total++;
      if (bus.rs_data !== 32'd0) begin
        bad++; $display("FAIL reset_rs[%0d]: got %h want 0", a, bus.rs_data);
      end
      total++;
      if (bus.rt_data !== 32'd0) begin
        bad++; $display("FAIL reset_rt[%0d]: got %h want 0", 31 - a, bus.rt_data);
      end
    end
    total++;
    if (bus.retire_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %h want 0", bus.retire_cnt);
    end
  endtask

  task automatic test_alu_write();
    drive(2'd0, 32'h0000_0020, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    #1;
    total++;
    if (bus.wb_we !== 1'b1 || bus.wb_reg !== 5'd5 || bus.wb_data !== 32'h1234_5678) begin
      bad++; $display("FAIL alu_wb: got we=%b reg=%0d data=%h want we=1 reg=5 data=12345678",
                      bus.wb_we, bus.wb_reg, bus.wb_data);
    end
    tick();
    bubble();
    bus.rs_addr = 5'd5;
    #1;
    total++;
    if (bus.rs_data !== 32'h1234_5678) begin
      bad++; $display("FAIL alu_read: got %h want 12345678", bus.rs_data);
    end
    total++;
    if (bus.retire_cnt !== 32'd1) begin
      bad++; $display("FAIL alu_cnt: got %h want 1", bus.retire_cnt);
    end
  endtask

  task automatic test_loads();
    logic [5:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [1:0]  adr  [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, {ops[i], 26'd0}, 5'd9, {30'h0000_1000, adr[i]}, 32'h80FF_7F01, 32'h0);
      #1;
      total++;
      if (bus.wb_data !== want[i]) begin
        bad++; $display("FAIL load[%0d]: got %h want %h", i, bus.wb_data, want[i]);
      end
      tick();
    end
    bubble();
    bus.rt_addr = 5'd9;
    #1;
    total++;
    if (bus.rt_data !== 32'h0000_7F01) begin
      bad++; $display("FAIL load_read: got %h want 00007f01", bus.rt_data);
    end
  endtask

  task automatic test_pc8_and_zero();
    drive(2'd2, 32'h0C00_0000, 5'd31, 32'h0, 32'h0, 32'h0000_3000);
    tick();
    drive(2'd0, 32'h0000_0020, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0);
    #1;
    total++;
    if (bus.wb_we !== 1'b0) begin
      bad++; $display("FAIL zero_we: got %b want 0", bus.wb_we);
    end
    tick();
    bubble();
    bus.rs_addr = 5'd31;
    bus.rt_addr = 5'd0;
    #1;
    total++;
    if (bus.rs_data !== 32'h0000_3008) begin
      bad++; $display("FAIL pc8_read: got %h want 00003008", bus.rs_data);
    end
    total++;
    if (bus.rt_data !== 32'd0) begin
      bad++; $display("FAIL zero_read: got %h want 0", bus.rt_data);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    drive(2'd0, 32'h0000_0020, 5'd8, 32'h1111_1111, 32'h0, 32'h0);
    tick();
    drive(2'd0, 32'h0000_0020, 5'd8, 32'hAAAA_5555, 32'h0, 32'h0);
    bus.rs_addr = 5'd8;
    bus.rt_addr = 5'd8;
`ifdef GRF_BYPASS_EN
    want = 32'hAAAA_5555;
`else
    want = 32'h1111_1111;
`endif
    #1;
    total++;
    if (bus.rs_data !== want) begin
      bad++; $display("FAIL bypass_rs: got %h want %h", bus.rs_data, want);
    end
    total++;
    if (bus.rt_data !== bus.rs_data || bus.rt_data !== want) begin
      bad++; $display("FAIL bypass_rt: got %h want %h", bus.rt_data, want);
    end
    tick();
    bubble();
    #1;
    total++;
    if (bus.rs_data !== 32'hAAAA_5555) begin
      bad++; $display("FAIL bypass_after: got %h want aaaa5555", bus.rs_data);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [7] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, 6'b001000, 6'b000000};
    logic [31:0] ins, exp_wb;
    logic [4:0]  tgt;
    for (int n = 0; n < 300; n++) begin
      tgt = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) ins = 32'd0;
      else ins = {ops[$urandom_range(0, 6)], 26'($urandom)} | 32'h1;
      drive(2'($urandom_range(0, 3)), ins, tgt, $urandom, $urandom, $urandom);
      bus.rs_addr = ($urandom_range(0, 2) == 0) ? tgt : 5'($urandom_range(0, 31));
      bus.rt_addr = ($urandom_range(0, 2) == 0) ? tgt : 5'($urandom_range(0, 31));
      #1;
      exp_wb = ref_wb_now();
      total++;
      if (bus.wb_data !== exp_wb) begin
        bad++; $display("FAIL rnd_wb[%0d]: got %h want %h", n, bus.wb_data, exp_wb);
      end
      total++;
      if (bus.wb_we !== (tgt != 5'd0) || bus.wb_reg !== tgt) begin
        bad++; $display("FAIL rnd_we[%0d]: got we=%b reg=%0d want reg=%0d",
                        n, bus.wb_we, bus.wb_reg, tgt);
      end
      total++;
      if (bus.rs_data !== ref_read(bus.rs_addr)) begin
        bad++; $display("FAIL rnd_rs[%0d]: got %h want %h", n, bus.rs_data, ref_read(bus.rs_addr));
      end
      total++;
      if (bus.rt_data !== ref_read(bus.rt_addr)) begin
        bad++; $display("FAIL rnd_rt[%0d]: got %h want %h", n, bus.rt_data, ref_read(bus.rt_addr));
      end
      tick();
      total++;
      if (bus.retire_cnt !== m_cnt) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %h want %h", n, bus.retire_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [31:0] held;
    for (int r = 1; r <= 4; r++) begin
      drive(2'd0, 32'h0000_0020, 5'(r), $urandom | 32'h1, 32'h0, 32'h0);
      tick();
    end
    bubble();
    held = m_cnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.retire_cnt !== held) begin
        bad++; $display("FAIL bubble_cnt[%0d]: got %h want %h", k, bus.retire_cnt, held);
      end
    end
    // Pending write plus an asynchronous reset in the same cycle
    drive(2'd0, 32'h0000_0020, 5'd2, 32'hCAFE_F00D, 32'h0, 32'h0);
    reset = 1'b0;
    model_clear();
    bus.rs_addr = 5'd1;
    bus.rt_addr = 5'd2;
    #1;
    total++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
      bad++; $display("FAIL mreset_12: got %h/%h want 0/0", bus.rs_data, bus.rt_data);
    end
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd4;
    #1;
    total++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
      bad++; $display("FAIL mreset_34: got %h/%h want 0/0", bus.rs_data, bus.rt_data);
    end
    total++;
    if (bus.retire_cnt !== 32'd0) begin
      bad++; $display("FAIL mreset_cnt: got %h want 0", bus.retire_cnt);
    end
    total++;
    if (bus.wb_we !== 1'b1 || bus.wb_data !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL mreset_comb: got we=%b data=%h want we=1 data=cafef00d",
                      bus.wb_we, bus.wb_data);
    end
    tick();
    bus.rs_addr = 5'd2;
    #1;
    total++;
    if (bus.rs_data !== 32'd0 || bus.retire_cnt !== 32'd0) begin
      bad++; $display("FAIL mreset_lost: got %h cnt=%h want 0 cnt=0", bus.rs_data, bus.retire_cnt);
    end
    reset = 1'b1;
    drive(2'd0, 32'h0000_0020, 5'd2, 32'h0000_0042, 32'h0, 32'h0);
    tick();
    bubble();
    #1;
    total++;
    if (bus.rs_data !== 32'h0000_0042 || bus.retire_cnt !== 32'd1) begin
      bad++; $display("FAIL release_write: got %h cnt=%h want 42 cnt=1", bus.rs_data, bus.retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_pc8_and_zero();
    test_bypass();
    test_random();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wb_grf

`default_nettype wire
